// File: rtl/vga_timing_gen_pkg.sv
// Shared 640x480@60 raster constants, total helpers and the coordinate type.
// No logic, no latency; nothing here applies backpressure.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int COORD_LIMIT = 1024;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Scan interface from the timing source to sprite renderers and the monitor.
// Pure wiring, no latency; the raster never stalls so there is no backpressure.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  coord_t DrawX;
  coord_t DrawY;
  logic   blank;
  logic   blank_d;
  logic   hs;
  logic   vs;
  logic   frame_end;
  logic   line_end;

  modport master (
    output DrawX, DrawY, blank, blank_d, hs, vs, frame_end, line_end
  );

  modport slave (
    input  DrawX, DrawY, blank, blank_d, hs, vs, frame_end, line_end
  );

endinterface

// File: rtl/vga_timing_gen_delay_line.sv
// Fixed-depth shift register with a per-bit reset value; DEPTH = 0 is a wire.
// Latency DEPTH cycles; free-running, no backpressure.
module delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst_n};
    assign dout = din;
  end else begin : g_stages
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage[i] <= RST_VAL;
        end
      end else begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) begin
          stage[i] <= stage[i-1];
        end
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters with undelayed coordinates/blank and PIPE_DELAY-aligned sync/blank_d.
// Counters: 0 cycles; hs/vs/blank_d: PIPE_DELAY cycles; free-running, no backpressure.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int PIPE_DELAY = 2
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > COORD_LIMIT || V_TOTAL > COORD_LIMIT) begin : g_total_chk
    $error("vga_timing_gen: line/frame totals must not exceed 1024");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_delay_chk
    $error("vga_timing_gen: PIPE_DELAY must be within 0..7");
  end

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT    = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT    = coord_t'(V_ACTIVE);
  localparam coord_t HS_BEGIN = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_BEGIN = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  coord_t     hc;
  coord_t     vc;
  logic       line_last;
  logic       frame_last;
  logic       blank_raw;
  logic       hs_raw;
  logic       vs_raw;
  logic [2:0] dly_out;

  assign line_last  = (hc == H_LAST);
  assign frame_last = line_last && (vc == V_LAST);

  // Both counters wrap on the same edge at the end of the frame.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc <= '0;
      vc <= '0;
    end else if (line_last) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? '0 : vc + coord_t'(1);
    end else begin
      hc <= hc + coord_t'(1);
    end
  end

  // Vertical sync covers whole lines, so it ignores hc entirely.
  assign blank_raw = (hc < H_ACT) && (vc < V_ACT);
  assign hs_raw    = !((hc >= HS_BEGIN) && (hc < HS_END));
  assign vs_raw    = !((vc >= VS_BEGIN) && (vc < VS_END));

  delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIPE_DELAY),
    .RST_VAL (3'b110)
  ) u_delay_line (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .din   ({hs_raw, vs_raw, blank_raw}),
    .dout  (dly_out)
  );

  assign vga.DrawX     = hc;
  assign vga.DrawY     = vc;
  assign vga.blank     = blank_raw;
  assign vga.hs        = dly_out[2];
  assign vga.vs        = dly_out[1];
  assign vga.blank_d   = dly_out[0];
  assign vga.line_end  = line_last;
  assign vga.frame_end = frame_last;

endmodule
